// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared types and constants for the FP adder arbiter
package fp_add_pkg;

    localparam int FP_W_DEF = 32;
    localparam int TMR_W    = $clog2(1024);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef logic req_id_t;

    function automatic logic [1:0] id_onehot(input req_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant, purely combinational
module rr_arbiter2
    import fp_add_pkg::*;
(
    input  logic [1:0] i_valid,
    input  req_id_t    i_rr_ptr,
    output logic       o_gnt_valid,
    output req_id_t    o_gnt
);

    // The preferred requester wins when valid; otherwise the other one gets it.
    always_comb begin
        o_gnt_valid = |i_valid;
        o_gnt       = i_rr_ptr;
        if (!i_valid[i_rr_ptr]) begin
            o_gnt = ~i_rr_ptr;
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - shares one multi-cycle FP add/sub unit between two requesters
module fp_add_arbiter
    import fp_add_pkg::*;
#(
    parameter int FP_W        = FP_W_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0][FP_W-1:0] req_a,
    input  logic [1:0][FP_W-1:0] req_b,
    input  logic [1:0]           req_sub,
    output logic                 fpu_start,
    output logic [FP_W-1:0]      fpu_a,
    output logic [FP_W-1:0]      fpu_b,
    output logic                 fpu_sub,
    input  logic                 fpu_done,
    input  logic [FP_W-1:0]      fpu_result,
    output logic [1:0]           rsp_valid,
    output logic [FP_W-1:0]      rsp_result,
    output logic                 rsp_err,
    input  logic [1:0]           rsp_ready,
    output logic                 busy
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    state_t            r_state;
    req_id_t           r_rr_ptr;
    req_id_t           r_owner;
    logic [TMR_W-1:0]  r_timer;
    logic              r_fpu_start;
    logic [FP_W-1:0]   r_fpu_a;
    logic [FP_W-1:0]   r_fpu_b;
    logic              r_fpu_sub;
    logic [1:0]        r_rsp_valid;
    logic [FP_W-1:0]   r_rsp_result;
    logic              r_rsp_err;
    logic              r_busy;

    logic              w_gnt_valid;
    req_id_t           w_gnt;

    rr_arbiter2 u_arb (
        .i_valid     (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt       (w_gnt)
    );

    assign req_ready  = (r_state == IDLE && w_gnt_valid) ? id_onehot(w_gnt) : 2'b00;
    assign fpu_start  = r_fpu_start;
    assign fpu_a      = r_fpu_a;
    assign fpu_b      = r_fpu_b;
    assign fpu_sub    = r_fpu_sub;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_err    = r_rsp_err;
    assign busy       = r_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_rr_ptr     <= 1'b0;
            r_owner      <= 1'b0;
            r_timer      <= '0;
            r_fpu_start  <= 1'b0;
            r_fpu_a      <= '0;
            r_fpu_b      <= '0;
            r_fpu_sub    <= 1'b0;
            r_rsp_valid  <= 2'b00;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_fpu_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_fpu_a     <= req_a[w_gnt];
                        r_fpu_b     <= req_b[w_gnt];
                        r_fpu_sub   <= req_sub[w_gnt];
                        r_owner     <= w_gnt;
                        r_fpu_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_timer <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the last timer count still wins over the abort.
                    if (fpu_done) begin
                        r_rsp_result <= fpu_result;
                        r_rsp_err    <= 1'b0;
                        r_rsp_valid  <= id_onehot(r_owner);
                        r_state      <= RESP;
                    end else if (r_timer == TMR_LAST) begin
                        r_rsp_result <= '0;
                        r_rsp_err    <= 1'b1;
                        r_rsp_valid  <= id_onehot(r_owner);
                        r_state      <= RESP;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready[r_owner]) begin
                        r_rsp_valid <= 2'b00;
                        r_rr_ptr    <= ~r_owner;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - randomized and directed bench with a transaction-level reference model
module tb_fp_add_arbiter;

    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_a = '0;
    logic [1:0][31:0] req_b = '0;
    logic [1:0]       req_sub = '0;
    logic             fpu_start;
    logic [31:0]      fpu_a, fpu_b;
    logic             fpu_sub;
    logic             fpu_done = 1'b0;
    logic [31:0]      fpu_result = '0;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_result;
    logic             rsp_err;
    logic [1:0]       rsp_ready = '0;
    logic             busy;

    always #5 clk = ~clk;

    fp_add_arbiter #(.FP_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sub(fpu_sub),
        .fpu_done(fpu_done), .fpu_result(fpu_result),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // staged stimulus, applied just after each rising edge
    logic [1:0]       d_valid = '0;
    logic [1:0][31:0] d_a = '0;
    logic [1:0][31:0] d_b = '0;
    logic [1:0]       d_sub = '0;
    logic [1:0]       d_rsp_ready = '0;
    bit               d_stray = 0;
    int               next_lat = 1;
    logic [31:0]      next_res = '0;

    // transaction-level model: one operation record plus round-robin pointer
    bit          m_active = 0;
    bit          m_owner = 0;
    bit          m_rr = 0;
    int          m_n = 0;
    int          m_lat = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_fa = '0, m_fb = '0;
    bit          m_fsub = 0;

    int          last_acc = 0;
    int          last_start = 0;
    logic [1:0]  s_rsp_valid;
    logic [31:0] s_rsp_result;
    logic        s_rsp_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [1:0] grant(input logic [1:0] v, input bit rr);
        if (v[rr]) return rr ? 2'b10 : 2'b01;
        if (v[!rr]) return rr ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    function automatic int rsp_cycle();
        return m_n + 2 + ((m_lat < TO) ? m_lat : TO);
    endfunction

    task automatic model_reset();
        m_active = 0; m_rr = 0; m_fa = '0; m_fb = '0; m_fsub = 0;
    endtask

    task automatic step();
        logic [1:0] exp_ready, exp_rv;
        bit real_done, stray_ok;
        @(posedge clk);
        #1;
        cyc++;
        real_done = m_active && (cyc == m_n + 1 + m_lat);
        stray_ok  = !m_active || (cyc == m_n + 1) || (cyc >= rsp_cycle());
        req_valid  = d_valid;
        req_a      = d_a;
        req_b      = d_b;
        req_sub    = d_sub;
        rsp_ready  = d_rsp_ready;
        fpu_done   = real_done || (d_stray && stray_ok);
        fpu_result = real_done ? m_res : $urandom;
        @(negedge clk);
        exp_ready = m_active ? 2'b00 : grant(d_valid, m_rr);
        exp_rv    = (m_active && cyc >= rsp_cycle()) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", req_ready, exp_ready);
        chk("busy", busy, m_active);
        chk("fpu_start", fpu_start, m_active && (cyc == m_n + 1));
        chk("fpu_a", fpu_a, m_fa);
        chk("fpu_b", fpu_b, m_fb);
        chk("fpu_sub", fpu_sub, m_fsub);
        chk("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv != 2'b00) begin
            chk("rsp_result", rsp_result, (m_lat <= TO) ? m_res : 32'h0);
            chk("rsp_err", rsp_err, m_lat > TO);
        end
        s_rsp_valid = rsp_valid; s_rsp_result = rsp_result; s_rsp_err = rsp_err;
        if (fpu_start) last_start = cyc;
        if (!m_active && exp_ready != 2'b00) begin
            m_owner  = exp_ready[1];
            m_fa     = d_a[m_owner];
            m_fb     = d_b[m_owner];
            m_fsub   = d_sub[m_owner];
            m_n      = cyc;
            m_lat    = next_lat;
            m_res    = next_res;
            m_active = 1;
            last_acc = cyc;
            d_valid[m_owner] = 1'b0;
        end else if (exp_rv != 2'b00 && d_rsp_ready[m_owner]) begin
            m_active = 0;
            m_rr     = !m_owner;
        end
    endtask

    task automatic wait_rsp(input string name, output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (s_rsp_valid != 2'b00) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            checks++;
            failures++;
            $display("FAIL %s no rsp_valid within 40 cycles", name);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        d_valid[i] = 1'b1; d_a[i] = a; d_b[i] = b; d_sub[i] = s;
    endtask

    initial begin
        int c;
        logic [31:0] held;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fpu_start", fpu_start, 1'b0);
        chk("rst_fpu_a", fpu_a, 32'h0);
        chk("rst_fpu_b", fpu_b, 32'h0);
        chk("rst_fpu_sub", fpu_sub, 1'b0);
        chk("rst_rsp_result", rsp_result, 32'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        #14 rst_n = 1'b1;
        step(); step();

        // 1: plain add, adder latency 3
        d_rsp_ready = 2'b11;
        set_req(0, 32'h40880000, 32'h40800000, 1'b0);
        next_lat = 3; next_res = 32'h41040000;
        wait_rsp("t1", c);
        chk("t1_start_lat", last_start - last_acc, 1);
        chk("t1_rsp_lat", c - last_acc, 5);
        chk("t1_valid", s_rsp_valid, 2'b01);
        chk("t1_result", s_rsp_result, 32'h41040000);
        chk("t1_err", s_rsp_err, 1'b0);

        // 2: requester 1 alone
        set_req(1, 32'hBE800000, 32'h3E800000, 1'b0);
        next_lat = 2; next_res = 32'h0;
        wait_rsp("t2", c);
        chk("t2_valid", s_rsp_valid, 2'b10);
        chk("t2_result", s_rsp_result, 32'h0);

        // 3: both valid; requester 0 first, requester 1 held
        set_req(0, 32'hBFE00000, 32'hBE800000, 1'b0);
        set_req(1, 32'hBF400000, 32'h00000000, 1'b0);
        next_lat = 4; next_res = 32'hC0000000;
        wait_rsp("t3a", c);
        chk("t3a_valid", s_rsp_valid, 2'b01);
        chk("t3a_result", s_rsp_result, 32'hC0000000);
        next_lat = 1; next_res = 32'hBF400000;
        wait_rsp("t3b", c);
        chk("t3b_valid", s_rsp_valid, 2'b10);
        chk("t3b_fpu_a", fpu_a, 32'hBF400000);
        chk("t3b_fpu_b", fpu_b, 32'h0);

        // 4: adder never finishes, then done exactly on the last timer count
        set_req(0, 32'h3F800000, 32'h3F800000, 1'b1);
        next_lat = 1000; next_res = 32'hDEADBEEF;
        wait_rsp("t4", c);
        chk("t4_wait_cycles", c - last_start - 1, TO);
        chk("t4_err", s_rsp_err, 1'b1);
        chk("t4_result", s_rsp_result, 32'h0);
        set_req(1, 32'h3F000000, 32'h3F000000, 1'b0);
        next_lat = TO; next_res = 32'h3F800000;
        wait_rsp("t4b", c);
        chk("t4b_lat", c - last_acc, TO + 2);
        chk("t4b_err", s_rsp_err, 1'b0);
        chk("t4b_result", s_rsp_result, 32'h3F800000);

        // 5: response back-pressure with non-owner ready and stray dones
        d_rsp_ready = 2'b10;
        set_req(0, 32'h11111111, 32'h22222222, 1'b0);
        next_lat = 2; next_res = 32'h12345678;
        wait_rsp("t5", c);
        held = s_rsp_result;
        chk("t5_result", held, 32'h12345678);
        set_req(1, 32'h33333333, 32'h44444444, 1'b1);
        d_stray = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_hold_valid", s_rsp_valid, 2'b01);
            chk("t5_hold_result", s_rsp_result, held);
        end
        d_stray = 0;
        d_rsp_ready = 2'b01;
        step();
        d_rsp_ready = 2'b11;
        next_lat = 1; next_res = 32'hCAFEF00D;
        wait_rsp("t5b", c);
        chk("t5b_valid", s_rsp_valid, 2'b10);
        d_stray = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_stray_busy", busy, 1'b0);
        end
        d_stray = 0;

        // 6: asynchronous reset while waiting on the adder
        set_req(0, 32'h55555555, 32'h66666666, 1'b0);
        next_lat = 1000; next_res = 32'h0;
        for (int i = 0; i < 4; i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_rsp_valid", rsp_valid, 2'b00);
        chk("t6_fpu_a", fpu_a, 32'h0);
        chk("t6_fpu_start", fpu_start, 1'b0);
        chk("t6_req_ready", req_ready, 2'b00);
        model_reset();
        step();
        d_stray = 1;
        step();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        d_stray = 0;
        chk("t6_idle", busy, 1'b0);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!d_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
            d_rsp_ready = 2'($urandom_range(0, 3));
            d_stray = ($urandom_range(0, 7) == 0);
            if (!m_active) begin
                next_lat = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(1, TO + 3);
                next_res = $urandom;
            end
            step();
        end
        d_valid = 2'b00; d_rsp_ready = 2'b11; d_stray = 0;
        for (int i = 0; i < 30; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
